// File: rtl/bf16_pkg.sv
// Shared types and constants for the bf16 adder arbiter slice.
package bf16_pkg;

    localparam int BF16_W = 16;

    localparam logic [BF16_W-1:0] BF16_ONE  = 16'h3F80;
    localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;
    localparam logic [BF16_W-1:0] BF16_QNAN = 16'hFFC0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_RES = 3'd2,
        RELEASE  = 3'd3,
        RETURN   = 3'd4
    } state_e;

endpackage

// File: rtl/bf16_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from rr_last+1, wrapping modulo NUM_REQ.
module bf16_rr_pick
    import bf16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_last,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_valid && req[(int'(rr_last) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'((int'(rr_last) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/bf16_adder_arbiter.sv
// Shares one non-pipelined bf16 adder between NUM_REQ requesters, round-robin.
// Optional statistics counters enabled by defining BF16_ARB_STATS_EN.
// The adder's synchronous active-high reset is tied to ~rst by the integrator.
//   state    | meaning
//   IDLE     | no operation; pick next requester
//   ISSUE    | adder_input_stb high until adder captures
//   WAIT_RES | waiting for adder_output_stb
//   RELEASE  | out_busy low until adder drops its output strobe
//   RETURN   | resp_stb held until owner accepts
module bf16_adder_arbiter
    import bf16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_stb,
    output logic [NUM_REQ-1:0]    req_busy,
    output logic [BF16_W-1:0]     resp_sum,
    output logic [NUM_REQ-1:0]    resp_stb,
    input  logic [NUM_REQ-1:0]    resp_busy,
    output logic [BF16_W-1:0]     adder_a,
    output logic [BF16_W-1:0]     adder_b,
    output logic                  adder_input_stb,
    input  logic                  adder_busy,
    input  logic [BF16_W-1:0]     adder_sum,
    input  logic                  adder_output_stb,
    output logic                  adder_out_busy,
    output logic [ID_W-1:0]       owner_id
`ifdef BF16_ARB_STATS_EN
    ,
    output logic [31:0]           op_count,
    output logic [31:0]           stall_count
`endif
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_ISSUE   = ISSUE;
    localparam logic [2:0] S_WAIT    = WAIT_RES;
    localparam logic [2:0] S_RELEASE = RELEASE;
    localparam logic [2:0] S_RETURN  = RETURN;

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] req_busy_q, req_busy_d;
    logic [NUM_REQ-1:0] resp_stb_q, resp_stb_d;
    logic [BF16_W-1:0]  resp_sum_q, resp_sum_d;
    logic [BF16_W-1:0]  adder_a_q, adder_a_d;
    logic [BF16_W-1:0]  adder_b_q, adder_b_d;
    logic               adder_input_stb_q, adder_input_stb_d;
    logic               adder_out_busy_q, adder_out_busy_d;
    logic [ID_W-1:0]    owner_id_q, owner_id_d;
    logic [ID_W-1:0]    rr_last_q, rr_last_d;

    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               ret_exit;
    logic [BF16_W-1:0]  a_arr [NUM_REQ];
    logic [BF16_W-1:0]  b_arr [NUM_REQ];

    bf16_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req         (req_stb),
        .rr_last     (rr_last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[16*i +: 16];
            b_arr[i] = req_b[16*i +: 16];
        end
    end

    assign ret_exit = (state_q == S_RETURN) && !resp_busy[owner_id_q];

    always_comb begin
        state_d           = state_q;
        req_busy_d        = req_busy_q;
        resp_stb_d        = resp_stb_q;
        resp_sum_d        = resp_sum_q;
        adder_a_d         = adder_a_q;
        adder_b_d         = adder_b_q;
        adder_input_stb_d = adder_input_stb_q;
        adder_out_busy_d  = adder_out_busy_q;
        owner_id_d        = owner_id_q;
        rr_last_d         = rr_last_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    adder_a_d         = a_arr[grant_id];
                    adder_b_d         = b_arr[grant_id];
                    owner_id_d        = grant_id;
                    req_busy_d        = '1;
                    adder_input_stb_d = 1'b1;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!adder_busy) begin
                    adder_input_stb_d = 1'b0;
                    state_d           = S_WAIT;
                end
            end
            S_WAIT: begin
                if (adder_output_stb) begin
                    resp_sum_d       = adder_sum;
                    adder_out_busy_d = 1'b0;
                    state_d          = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Keep out_busy low until the adder has seen it and dropped its strobe
                if (!adder_output_stb) begin
                    adder_out_busy_d = 1'b1;
                    resp_stb_d       = NUM_REQ'(1) << owner_id_q;
                    state_d          = S_RETURN;
                end
            end
            S_RETURN: begin
                if (ret_exit) begin
                    resp_stb_d = '0;
                    rr_last_d  = owner_id_q;
                    req_busy_d = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= S_IDLE;
            req_busy_q        <= '0;
            resp_stb_q        <= '0;
            resp_sum_q        <= '0;
            adder_a_q         <= '0;
            adder_b_q         <= '0;
            adder_input_stb_q <= 1'b0;
            adder_out_busy_q  <= 1'b1;
            owner_id_q        <= '0;
            rr_last_q         <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q           <= state_d;
            req_busy_q        <= req_busy_d;
            resp_stb_q        <= resp_stb_d;
            resp_sum_q        <= resp_sum_d;
            adder_a_q         <= adder_a_d;
            adder_b_q         <= adder_b_d;
            adder_input_stb_q <= adder_input_stb_d;
            adder_out_busy_q  <= adder_out_busy_d;
            owner_id_q        <= owner_id_d;
            rr_last_q         <= rr_last_d;
        end
    end

    assign req_busy        = req_busy_q;
    assign resp_stb        = resp_stb_q;
    assign resp_sum        = resp_sum_q;
    assign adder_a         = adder_a_q;
    assign adder_b         = adder_b_q;
    assign adder_input_stb = adder_input_stb_q;
    assign adder_out_busy  = adder_out_busy_q;
    assign owner_id        = owner_id_q;

`ifdef BF16_ARB_STATS_EN
    logic [31:0] op_count_q, op_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        stall;

    // A stall is any non-owner still requesting while an operation is in flight
    assign stall = (state_q != S_IDLE) &&
                   (|(req_stb & ~(NUM_REQ'(1) << owner_id_q)));

    always_comb begin
        op_count_d    = op_count_q + (ret_exit ? 32'd1 : 32'd0);
        stall_count_d = stall_count_q + (stall ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            op_count_q    <= op_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_bf16_adder_arbiter.sv
// Directed bench for bf16_adder_arbiter with a behavioural variable-latency adder.
// Checks the statistics ports as well when BF16_ARB_STATS_EN is defined.
module tb_bf16_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_stb;
    logic [NUM_REQ-1:0]    req_busy;
    logic [15:0]           resp_sum;
    logic [NUM_REQ-1:0]    resp_stb;
    logic [NUM_REQ-1:0]    resp_busy;
    logic [15:0]           adder_a;
    logic [15:0]           adder_b;
    logic                  adder_input_stb;
    logic                  adder_busy;
    logic [15:0]           adder_sum;
    logic                  adder_output_stb;
    logic                  adder_out_busy;
    logic [ID_W-1:0]       owner_id;
`ifdef BF16_ARB_STATS_EN
    logic [31:0]           op_count;
    logic [31:0]           stall_count;
`endif

    int vectors = 0;
    int errors  = 0;

    bf16_adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_stb          (req_stb),
        .req_busy         (req_busy),
        .resp_sum         (resp_sum),
        .resp_stb         (resp_stb),
        .resp_busy        (resp_busy),
        .adder_a          (adder_a),
        .adder_b          (adder_b),
        .adder_input_stb  (adder_input_stb),
        .adder_busy       (adder_busy),
        .adder_sum        (adder_sum),
        .adder_output_stb (adder_output_stb),
        .adder_out_busy   (adder_out_busy),
        .owner_id         (owner_id)
`ifdef BF16_ARB_STATS_EN
        ,
        .op_count         (op_count),
        .stall_count      (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder: fixed table of hand-computed bf16 sums, QNAN otherwise.
    function automatic logic [15:0] table_add(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            {16'h3F80, 16'h4000}: return 16'h4040;
            {16'h3F80, 16'hBF80}: return 16'h0000;
            {16'h3F80, 16'h3F80}: return 16'h4000;
            {16'h4000, 16'h4000}: return 16'h4080;
            {16'h3FC0, 16'h3FC0}: return 16'h4040;
            default:              return 16'hFFC0;
        endcase
    endfunction

    logic [1:0]  m_st;
    logic [15:0] m_res;
    int          m_cnt;
    int          m_lat = 3;

    always @(posedge clk) begin
        if (!rst) begin
            m_st             <= 2'd0;
            adder_busy       <= 1'b0;
            adder_output_stb <= 1'b0;
            adder_sum        <= 16'h0000;
            m_cnt            <= 0;
        end else begin
            case (m_st)
                2'd0: if (adder_input_stb && !adder_busy) begin
                    m_res      <= table_add(adder_a, adder_b);
                    m_cnt      <= m_lat;
                    adder_busy <= 1'b1;
                    m_st       <= 2'd1;
                end
                2'd1: if (m_cnt == 0) begin
                    adder_output_stb <= 1'b1;
                    adder_sum        <= m_res;
                    m_st             <= 2'd2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (!adder_out_busy) begin
                    adder_output_stb <= 1'b0;
                    adder_busy       <= 1'b0;
                    m_st             <= 2'd0;
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b);
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        req_stb[id]        = 1'b1;
    endtask

    task automatic wait_resp(output bit ok, output bit busy_ok);
        ok      = 1'b0;
        busy_ok = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_busy !== 4'hF) busy_ok = 1'b0;
            if (resp_stb !== 4'h0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge just after the grant edge; ends in IDLE after RETURN exit.
    task automatic serve(input int id, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] es);
        bit         ok;
        bit         busy_ok;
        logic [3:0] onehot;
        onehot = 4'b0001 << id;
        chk("grant_owner", 32'(owner_id), 32'(id));
        chk("grant_req_busy", 32'(req_busy), 32'hF);
        chk("grant_adder_a", 32'(adder_a), 32'(ea));
        chk("grant_adder_b", 32'(adder_b), 32'(eb));
        chk("grant_input_stb", 32'(adder_input_stb), 32'h1);
        req_stb[id] = 1'b0;
        wait_resp(ok, busy_ok);
        chk("resp_timeout", 32'(ok), 32'h1);
        chk("req_busy_held", 32'(busy_ok), 32'h1);
        chk("resp_stb", 32'(resp_stb), 32'(onehot));
        chk("resp_sum", 32'(resp_sum), 32'(es));
        chk("resp_out_busy", 32'(adder_out_busy), 32'h1);
        @(negedge clk);
        chk("exit_resp_stb", 32'(resp_stb), 32'h0);
        chk("exit_req_busy", 32'(req_busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        bit   busy_ok;
        bit   hold_ok;

        rst       = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_stb   = '0;
        resp_busy = '0;
        repeat (3) @(negedge clk);

        chk("rst_req_busy", 32'(req_busy), 32'h0);
        chk("rst_resp_stb", 32'(resp_stb), 32'h0);
        chk("rst_resp_sum", 32'(resp_sum), 32'h0);
        chk("rst_adder_a", 32'(adder_a), 32'h0);
        chk("rst_adder_b", 32'(adder_b), 32'h0);
        chk("rst_input_stb", 32'(adder_input_stb), 32'h0);
        chk("rst_out_busy", 32'(adder_out_busy), 32'h1);
        chk("rst_owner", 32'(owner_id), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single requester: 1.0 + 2.0 = 3.0
        set_req(1, 16'h3F80, 16'h4000);
        @(negedge clk);
        serve(1, 16'h3F80, 16'h4000, 16'h4040);

        // Cancellation: 1.0 + -1.0 = +0
        set_req(2, 16'h3F80, 16'hBF80);
        @(negedge clk);
        serve(2, 16'h3F80, 16'hBF80, 16'h0000);

        // Contention straight after reset: order 0, 2, 3
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_req(0, 16'h3F80, 16'h3F80);
        set_req(2, 16'h4000, 16'h4000);
        set_req(3, 16'h3F80, 16'h4000);
        @(negedge clk);
        serve(0, 16'h3F80, 16'h3F80, 16'h4000);
        @(negedge clk);
        serve(2, 16'h4000, 16'h4000, 16'h4080);
        @(negedge clk);
        serve(3, 16'h3F80, 16'h4000, 16'h4040);

        // rr_last = 3, so 0 wins over 3
        set_req(0, 16'h4000, 16'h4000);
        set_req(3, 16'h3F80, 16'hBF80);
        @(negedge clk);
        serve(0, 16'h4000, 16'h4000, 16'h4080);
        @(negedge clk);
        serve(3, 16'h3F80, 16'hBF80, 16'h0000);
`ifdef BF16_ARB_STATS_EN
        chk("stats_op_count", op_count, 32'd5);
        chk("stats_stall_seen", 32'(stall_count >= 32'd1), 32'h1);
`endif

        // Response backpressure on owner 1 for 10 cycles with requester 2 waiting
        resp_busy = 4'b0010;
        set_req(1, 16'h3F80, 16'h4000);
        @(negedge clk);
        chk("bp_owner", 32'(owner_id), 32'h1);
        req_stb[1] = 1'b0;
        wait_resp(ok, busy_ok);
        chk("bp_resp_timeout", 32'(ok), 32'h1);
        set_req(2, 16'h3F80, 16'h3F80);
        hold_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (resp_stb !== 4'b0010 || resp_sum !== 16'h4040 || adder_out_busy !== 1'b1 ||
                owner_id !== 2'd1 || req_busy !== 4'hF || adder_input_stb !== 1'b0)
                hold_ok = 1'b0;
        end
        chk("bp_hold_stable", 32'(hold_ok), 32'h1);
        resp_busy = 4'b0000;
        @(negedge clk);
        chk("bp_exit_resp_stb", 32'(resp_stb), 32'h0);
        chk("bp_exit_req_busy", 32'(req_busy), 32'h0);
        @(negedge clk);
        serve(2, 16'h3F80, 16'h3F80, 16'h4000);

        // Reset during WAIT_RES is asynchronous and discards the result
        m_lat = 8;
        set_req(0, 16'h3F80, 16'h4000);
        @(negedge clk);
        chk("mid_owner", 32'(owner_id), 32'h0);
        req_stb[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_in_wait_stb", 32'(adder_input_stb), 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("async_req_busy", 32'(req_busy), 32'h0);
        chk("async_resp_sum", 32'(resp_sum), 32'h0);
        chk("async_adder_a", 32'(adder_a), 32'h0);
        chk("async_adder_b", 32'(adder_b), 32'h0);
        chk("async_out_busy", 32'(adder_out_busy), 32'h1);
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        m_lat = 3;
        @(negedge clk);
        set_req(0, 16'h3FC0, 16'h3FC0);
        @(negedge clk);
        serve(0, 16'h3FC0, 16'h3FC0, 16'h4040);
`ifdef BF16_ARB_STATS_EN
        chk("stats_after_reset", op_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
